unified_mem_ctrl: RTL and testbench
===================================

# unified_mem_ctrl

Sequences a single-port, asynchronous-read / synchronous-write 64-word memory shared by the CPU fetch port and the load/store port, so one array replaces separate instruction and data memories. It sits between the fetch stage and the memory stage on one side and the memory array on the other. Per access it arbitrates, latches the request, drives one memory cycle and returns a registered response. Data has priority, with a starvation guard for fetch.

## Interface
- ADDR_W, 6: word-address width (64 words)
- DATA_W, 32: data width
- STARVE_MAX, 4: consecutive lost arbitrations after which fetch wins once
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  synchronous, active-high reset
- if_req  in  1  fetch request
- if_addr  in  ADDR_W  fetch word address
- if_gnt  out  1  fetch request accepted this cycle (combinational)
- if_valid  out  1  fetch response pulse
- if_rdata  out  DATA_W  fetched instruction (registered)
- dm_req  in  1  data request
- dm_we  in  1  1 = store, 0 = load
- dm_addr  in  ADDR_W  data word address
- dm_wdata  in  DATA_W  store data, pre-aligned to byte lanes
- dm_be  in  4  store byte enables
- dm_gnt  out  1  data request accepted this cycle (combinational)
- dm_valid  out  1  data response / store ack pulse
- dm_rdata  out  DATA_W  load data, full word (registered)
- mem_en, mem_we  out  1 each  memory enable, write enable
- mem_addr  out  ADDR_W  memory word address
- mem_wdata  out  DATA_W  memory write data
- mem_be  out  4  memory byte enables
- mem_rdata  in  DATA_W  asynchronous read data

## Operation
- FSM states: IDLE, ACCESS.
- IDLE, any req high: arbitrate and assert exactly one gnt.
  - On that edge, latch port id, we, addr, wdata and be, then go to ACCESS.
  - A port must hold its req and fields stable until its gnt.
- ACCESS: drive mem_en=1 and mem_addr, mem_we, mem_wdata, mem_be from the latch. Next edge returns to IDLE.
- Fetch drives mem_we=0 and mem_be=4'hF.
- Load (dm_we=0) drives mem_be=4'hF. Byte/half extraction and sign extension belong to the memory stage, not this block.
- End of ACCESS edge:
  - Read: capture mem_rdata into the owner's rdata register.
  - Read or write: set the owner's valid for exactly one cycle.
  - Stores leave dm_rdata unchanged.
- Priority:
  - Data wins by default.
  - starve_cnt increments each IDLE cycle in which if_req is high and data is granted. It saturates at STARVE_MAX.
  - When starve_cnt == STARVE_MAX and both requests are high, fetch wins.
  - starve_cnt clears on any fetch grant.
- Only one port is granted per arbitration. The losing request stays pending, since the requester keeps req high.
- In ACCESS, both gnt are 0.

## Timing
- Reset values: state IDLE, if_valid/dm_valid 0, if_rdata/dm_rdata 0, starve_cnt 0, latch 0, all mem_* 0.
- Reset mid-ACCESS: mem_en and mem_we are gated by !rst, so no write commits on a reset edge. The pending response is dropped and no valid is produced.
- Latency:
  - gnt in cycle k (IDLE).
  - ACCESS in cycle k+1.
  - valid and rdata in cycle k+2.
- Throughput: one access per 2 cycles. A new gnt may be issued in the same IDLE cycle that valid pulses (back-to-back).
- Simultaneous requests: the loser receives gnt in the cycle its competitor's valid pulses, at the earliest.
- Address wrap: addr is exactly ADDR_W bits, with no range check. Word 63 is followed by word 0 with no special handling.
- gnt is combinational from state, req and starve_cnt. The rdata outputs and valid pulses are registered.

## Structure
- Shared package mem_ctrl_pkg: state enum (IDLE, ACCESS), port-id constants (PORT_IF, PORT_DM), default widths.
- One sub-module, mem_arb_pri: combinational two-way priority with the starve_cnt input. It returns the winner and the gnt vector.
- The memory array stays outside this block.

## Test plan
- Single fetch: if_req with if_addr=1, mem[1]=32'h00002E17 -> if_gnt at k, if_valid at k+2, if_rdata=32'h00002E17.
- Store then load: dm store to addr 3, wdata=32'hDEADBEEF, be=4'b0011, prior word 0 -> store ack at k+2. A later load of addr 3 returns 32'h0000BEEF.
- Contention: if_req and dm_req both held continuously -> 4 data grants, then 1 fetch grant, then the pattern repeats. starve_cnt returns to 0 after the fetch grant.
- Back-to-back: dm_valid and if_gnt fall in the same cycle. if_valid follows 2 cycles later, with no idle bubble.
- Reset mid-ACCESS of a store to addr 5 -> mem[5] unchanged, no dm_valid, FSM IDLE, starve_cnt 0.
- Address wrap: fetch addr 63 then addr 0 -> each returns its own word, with correct valid timing.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared types for the unified instruction/data memory controller.
// State encoding, port identifiers and default geometry.
package mem_ctrl_pkg;

  localparam int ADDR_W_DEF     = 6;
  localparam int DATA_W_DEF     = 32;
  localparam int STARVE_MAX_DEF = 4;
  localparam int BE_W           = 4;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_e;

  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_DM = 1'b1;

endpackage

// File: rtl/mem_arb_pri.sv
// Two-way fixed-priority arbiter (data first) with a starvation override for fetch.
// Purely combinational; grants only while en_i is high.
module mem_arb_pri
  import mem_ctrl_pkg::*;
#(
  parameter int CNT_W      = 3,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic             en_i,
  input  logic             if_req_i,
  input  logic             dm_req_i,
  input  logic [CNT_W-1:0] starve_cnt_i,
  output logic             winner_o,
  output logic [1:0]       gnt_o
);

  logic starved;

  assign starved = (starve_cnt_i == CNT_W'(STARVE_MAX));

  always_comb begin
    gnt_o    = 2'b00;
    winner_o = PORT_DM;
    if (en_i) begin
      if (if_req_i && (!dm_req_i || starved)) begin
        winner_o       = PORT_IF;
        gnt_o[PORT_IF] = 1'b1;
      end else if (dm_req_i) begin
        gnt_o[PORT_DM] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/unified_mem_ctrl.sv
// Shares one async-read/sync-write word memory between fetch and load/store ports.
// gnt at k, memory cycle at k+1, registered valid/rdata at k+2; one access per two cycles.
module unified_mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  input  logic [3:0]        dm_be,
  output logic              dm_gnt,
  output logic              dm_valid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_be,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  starve_q, starve_d;
  logic              port_q, port_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [3:0]        be_q, be_d;
  logic              if_valid_q, if_valid_d;
  logic              dm_valid_q, dm_valid_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;

  logic              winner;
  logic [1:0]        gnt;
  logic              in_access;

  mem_arb_pri #(
    .CNT_W      (CNT_W),
    .STARVE_MAX (STARVE_MAX)
  ) u_arb (
    .en_i         (state_q == IDLE),
    .if_req_i     (if_req),
    .dm_req_i     (dm_req),
    .starve_cnt_i (starve_q),
    .winner_o     (winner),
    .gnt_o        (gnt)
  );

  always_comb begin
    state_d    = state_q;
    starve_d   = starve_q;
    port_d     = port_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    if_valid_d = 1'b0;
    dm_valid_d = 1'b0;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;
    case (state_q)
      IDLE: begin
        if (|gnt) begin
          state_d = ACCESS;
          port_d  = winner;
          if (winner == PORT_IF) begin
            we_d    = 1'b0;
            addr_d  = if_addr;
            wdata_d = '0;
            be_d    = 4'hF;
          end else begin
            we_d    = dm_we;
            addr_d  = dm_addr;
            wdata_d = dm_wdata;
            be_d    = dm_we ? dm_be : 4'hF;
          end
        end
        // Counts only arbitrations that fetch actually lost to data.
        if (gnt[PORT_IF]) begin
          starve_d = '0;
        end else if (gnt[PORT_DM] && if_req && (starve_q != CNT_W'(STARVE_MAX))) begin
          starve_d = starve_q + CNT_W'(1);
        end
      end
      ACCESS: begin
        state_d = IDLE;
        if (port_q == PORT_IF) begin
          if_valid_d = 1'b1;
          if_rdata_d = mem_rdata;
        end else begin
          dm_valid_d = 1'b1;
          if (!we_q) begin
            dm_rdata_d = mem_rdata;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      starve_q   <= '0;
      port_q     <= PORT_IF;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      if_valid_q <= 1'b0;
      dm_valid_q <= 1'b0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      starve_q   <= starve_d;
      port_q     <= port_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      be_q       <= be_d;
      if_valid_q <= if_valid_d;
      dm_valid_q <= dm_valid_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
    end
  end

  assign in_access = (state_q == ACCESS);

  // Enables are gated by rst so a reset edge can never commit a write.
  assign mem_en    = in_access && !rst;
  assign mem_we    = in_access && we_q && !rst;
  assign mem_addr  = in_access ? addr_q  : '0;
  assign mem_wdata = in_access ? wdata_q : '0;
  assign mem_be    = in_access ? be_q    : '0;

  assign if_gnt   = gnt[PORT_IF];
  assign dm_gnt   = gnt[PORT_DM];
  assign if_valid = if_valid_q;
  assign dm_valid = dm_valid_q;
  assign if_rdata = if_rdata_q;
  assign dm_rdata = dm_rdata_q;

endmodule

// File: tb/tb_unified_mem_ctrl.sv
// Bench for unified_mem_ctrl: table-driven accesses, an arbitration/response scoreboard,
// and hand sequences for contention, back-to-back, reset mid-access.
module tb_unified_mem_ctrl;
  import mem_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_init = 1'b1;
  logic        if_req = 1'b0;
  logic [5:0]  if_addr = '0;
  logic        if_gnt, if_valid;
  logic [31:0] if_rdata;
  logic        dm_req = 1'b0;
  logic        dm_we = 1'b0;
  logic [5:0]  dm_addr = '0;
  logic [31:0] dm_wdata = '0;
  logic [3:0]  dm_be = '0;
  logic        dm_gnt, dm_valid;
  logic [31:0] dm_rdata;
  logic        mem_en, mem_we;
  logic [5:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata;

  logic [31:0] mem_arr [64];
  logic [31:0] ref_mem [64];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  typedef struct {
    logic        port;
    logic        we;
    logic [5:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          due;
  } acc_t;

  typedef struct {
    logic        port;
    logic        we;
    logic [5:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp;
  } vec_t;

  acc_t sb[$];
  logic gnt_log[$];

  unified_mem_ctrl #(.ADDR_W(6), .DATA_W(32), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_valid(if_valid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_be(dm_be), .dm_gnt(dm_gnt), .dm_valid(dm_valid), .dm_rdata(dm_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] init_word(input int i);
    case (i)
      0:       return 32'h1234_5678;
      1:       return 32'h0000_2E17;
      3:       return 32'h0000_0000;
      5:       return 32'h5555_AAAA;
      63:      return 32'hCAFE_F00D;
      default: return 32'h1000_0000 | 32'(i);
    endcase
  endfunction

  // External memory array: asynchronous read, byte-enabled synchronous write.
  assign mem_rdata = mem_arr[mem_addr];
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 64; i++) mem_arr[i] <= init_word(i);
    end else if (mem_en && mem_we) begin
      for (int b = 0; b < 4; b++)
        if (mem_be[b]) mem_arr[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard/arbitration model, sampled mid-cycle.
  logic        busy = 1'b0;
  int          starve = 0;
  logic [31:0] last_dm = '0;
  always @(posedge clk) begin
    acc_t e;
    logic exp_if, exp_dm;
    logic [31:0] w;
    #2;
    if (mem_init) for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
    if (rst) begin
      sb.delete();
      busy = 1'b0;
      starve = 0;
      last_dm = '0;
    end else begin
      if (if_valid && dm_valid) chk("both_valid", 32'd1, 32'd0);
      if (if_valid || dm_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_valid", {30'd0, if_valid, dm_valid}, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("rsp_port", 32'(dm_valid), 32'(e.port));
          chk("rsp_cycle", 32'(cyc), 32'(e.due));
          if (e.we) begin
            w = ref_mem[e.addr];
            for (int b = 0; b < 4; b++) if (e.be[b]) w[8*b +: 8] = e.wdata[8*b +: 8];
            ref_mem[e.addr] = w;
            chk("store_keeps_rdata", dm_rdata, last_dm);
          end else if (e.port == PORT_IF) begin
            chk("if_rdata", if_rdata, ref_mem[e.addr]);
          end else begin
            chk("dm_rdata", dm_rdata, ref_mem[e.addr]);
            last_dm = ref_mem[e.addr];
          end
        end
      end
      chk("mem_en", 32'(mem_en), 32'(busy));
      if (busy && sb.size() > 0) begin
        chk("mem_addr", 32'(mem_addr), 32'(sb[0].addr));
        chk("mem_we", 32'(mem_we), 32'(sb[0].we));
        chk("mem_be", 32'(mem_be), 32'(sb[0].be));
        if (sb[0].we) chk("mem_wdata", mem_wdata, sb[0].wdata);
      end
      exp_if = !busy && if_req && (!dm_req || starve == 4);
      exp_dm = !busy && dm_req && !exp_if;
      if (if_req || dm_req || if_gnt || dm_gnt)
        chk("gnt", {30'd0, if_gnt, dm_gnt}, {30'd0, exp_if, exp_dm});
      if (if_gnt) begin
        sb.push_back('{PORT_IF, 1'b0, if_addr, 32'd0, 4'hF, cyc + 2});
        gnt_log.push_back(PORT_IF);
      end else if (dm_gnt) begin
        sb.push_back('{PORT_DM, dm_we, dm_addr, dm_wdata, dm_we ? dm_be : 4'hF, cyc + 2});
        gnt_log.push_back(PORT_DM);
      end
      if (exp_if) starve = 0;
      else if (exp_dm && if_req && starve < 4) starve++;
      busy = exp_if || exp_dm;
    end
  end

  // Entered 1 time unit after an edge; returns 1 time unit after the accepting edge.
  task automatic wait_gnt(input logic is_if, output logic ok);
    ok = 1'b0;
    for (int t = 0; t < 20; t++) begin
      #1;
      if (is_if ? if_gnt : dm_gnt) ok = 1'b1;
      @(posedge clk); #1;
      if (ok) break;
    end
    if (!ok) chk(is_if ? "if_gnt_timeout" : "dm_gnt_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    logic ok, got;
    if (v.port == PORT_IF) begin
      if_req = 1'b1; if_addr = v.addr;
    end else begin
      dm_req = 1'b1; dm_we = v.we; dm_addr = v.addr; dm_wdata = v.wdata; dm_be = v.be;
    end
    wait_gnt(v.port == PORT_IF, ok);
    if_req = 1'b0; dm_req = 1'b0;
    got = 1'b0;
    if (ok) begin
      for (int t = 0; t < 4; t++) begin
        @(posedge clk); #1;
        if (v.port == PORT_IF ? if_valid : dm_valid) begin got = 1'b1; break; end
      end
      if (!got) chk($sformatf("vec%0d_valid_timeout", idx), 32'd0, 32'd1);
      else if (v.port == PORT_IF) chk($sformatf("vec%0d_if_rdata", idx), if_rdata, v.exp);
      else if (!v.we) chk($sformatf("vec%0d_dm_rdata", idx), dm_rdata, v.exp);
    end
  endtask

  initial begin
    vec_t vecs[12];
    logic ok;
    vecs[0]  = '{PORT_IF, 1'b0, 6'd1,  32'h0,         4'h0,    32'h0000_2E17};
    vecs[1]  = '{PORT_DM, 1'b1, 6'd3,  32'hDEAD_BEEF, 4'b0011, 32'h0};
    vecs[2]  = '{PORT_DM, 1'b0, 6'd3,  32'h0,         4'h0,    32'h0000_BEEF};
    vecs[3]  = '{PORT_IF, 1'b0, 6'd63, 32'h0,         4'h0,    32'hCAFE_F00D};
    vecs[4]  = '{PORT_IF, 1'b0, 6'd0,  32'h0,         4'h0,    32'h1234_5678};
    vecs[5]  = '{PORT_DM, 1'b1, 6'd63, 32'h1122_3344, 4'b1100, 32'h0};
    vecs[6]  = '{PORT_DM, 1'b0, 6'd63, 32'h0,         4'h0,    32'h1122_F00D};
    vecs[7]  = '{PORT_DM, 1'b1, 6'd10, 32'hAABB_CCDD, 4'b1111, 32'h0};
    vecs[8]  = '{PORT_IF, 1'b0, 6'd10, 32'h0,         4'h0,    32'hAABB_CCDD};
    vecs[9]  = '{PORT_DM, 1'b0, 6'd7,  32'h0,         4'h0,    32'h1000_0007};
    vecs[10] = '{PORT_DM, 1'b1, 6'd7,  32'h0099_0000, 4'b0100, 32'h0};
    vecs[11] = '{PORT_DM, 1'b0, 6'd7,  32'h0,         4'h0,    32'h1099_0007};

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    mem_init = 1'b0;
    chk("rst_valid", {30'd0, if_valid, dm_valid}, 32'd0);
    chk("rst_if_rdata", if_rdata, 32'd0);
    chk("rst_dm_rdata", dm_rdata, 32'd0);
    chk("rst_mem_ctl", {20'd0, mem_en, mem_we, mem_be, mem_addr}, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);

    for (int i = 0; i < 12; i++) run_vec(vecs[i], i);

    // Back-to-back: fetch granted in the same cycle the load's valid pulses.
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 6'd3;
    wait_gnt(1'b0, ok);
    dm_req = 1'b0;
    if_req = 1'b1; if_addr = 6'd1;
    #1 chk("b2b_access_no_gnt", {30'd0, if_gnt, dm_gnt}, 32'd0);
    @(posedge clk); #1;
    chk("b2b_dm_valid", 32'(dm_valid), 32'd1);
    chk("b2b_dm_rdata", dm_rdata, 32'h0000_BEEF);
    #1 chk("b2b_if_gnt", 32'(if_gnt), 32'd1);
    @(posedge clk); #1;
    if_req = 1'b0;
    chk("b2b_if_valid_early", 32'(if_valid), 32'd0);
    @(posedge clk); #1;
    chk("b2b_if_valid", 32'(if_valid), 32'd1);
    chk("b2b_if_rdata", if_rdata, 32'h0000_2E17);

    // Contention: both requests held continuously.
    repeat (2) @(posedge clk);
    #1;
    gnt_log.delete();
    if_req = 1'b1; if_addr = 6'd20;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 6'd21;
    repeat (30) @(posedge clk);
    #1;
    if_req = 1'b0; dm_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("cont_grants", 32'(gnt_log.size()), 32'd15);
    for (int i = 0; i < 15 && i < gnt_log.size(); i++)
      chk($sformatf("cont_gnt%0d", i), 32'(gnt_log[i]), (i % 5 == 4) ? 32'(PORT_IF) : 32'(PORT_DM));
    chk("cont_starve_clear", 32'(dut.starve_q), 32'd0);

    // Reset during the memory cycle of a store.
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 6'd5; dm_wdata = 32'hFFFF_FFFF; dm_be = 4'hF;
    wait_gnt(1'b0, ok);
    dm_req = 1'b0;
    rst = 1'b1;
    #1 chk("rstmid_mem_gate", {30'd0, mem_en, mem_we}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rstmid_no_valid", 32'(dm_valid), 32'd0);
    chk("rstmid_mem5", mem_arr[5], 32'h5555_AAAA);
    chk("rstmid_state", 32'(dut.state_q), 32'(IDLE));
    chk("rstmid_starve", 32'(dut.starve_q), 32'd0);
    @(posedge clk); #1;
    chk("rstmid_no_valid_late", 32'(dm_valid), 32'd0);

    repeat (3) @(posedge clk);
    #1;
    chk("sb_drain", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
